// File: rtl/stopwatch_core_if.sv
// Control pulses and display outputs between the button stage, stopwatch_core
// and the seven-segment driver. The dbg_state field exposes the FSM state.
interface stopwatch_core_if;
  // start_stop, clear and lap are single-cycle pulses. They are sampled on every
  // rising clk edge with no ready/backpressure. A pulse held for N cycles acts
  // as N separate pulses.
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [31:0] display;
  logic [7:0]  digit_enable;
  logic [7:0]  dp_enable;
  logic        running;
  logic        overflow;
  logic        lap_active;
  logic [1:0]  dbg_state;

  modport master (
    output start_stop, clear, lap,
    input  display, digit_enable, dp_enable, running, overflow, lap_active,
    input  dbg_state
  );

  modport slave (
    input  start_stop, clear, lap,
    output display, digit_enable, dp_enable, running, overflow, lap_active,
    output dbg_state
  );
endinterface

// File: rtl/stopwatch_core.sv
// BCD stopwatch (HH:MM:SS.hh) feeding the 8-digit seven-segment driver.
// Optional lap freeze is built when the macro STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int TICK_HZ    = 100
) (
  input logic             clk,
  input logic             resetn,
  stopwatch_core_if.slave sw
);
  localparam int DIV = CLOCK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LOAD = PW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  // Each digit's wrap limit. Read as one word, this is also the maximum time.
  localparam logic [31:0] TIME_MAX = 32'h9959_5999;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   time_q, time_d;
  logic [31:0]   display_q, display_d;
  logic          lap_q, lap_d;
  logic          tick;
  logic          at_max;
  logic [7:0]    digit_en;

  function automatic logic [31:0] bcd_inc(input logic [31:0] t);
    logic [31:0] r;
    logic        carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == TIME_MAX[4*i +: 4]) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick   = (state_q == S_RUN) && (presc_q == '0);
  assign at_max = (time_q == TIME_MAX);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    lap_d   = lap_q;

`ifdef STOPWATCH_LAP_EN
    if (sw.lap) begin
      if (lap_q) begin
        lap_d = 1'b0;
      end else if (state_q == S_RUN) begin
        lap_d = 1'b1;
      end
    end
`else
    // lap_q never leaves 0 here. The input is still consumed so the port stays live.
    lap_d = lap_q & sw.lap;
`endif

    case (state_q)
      S_IDLE: begin
        if (sw.start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (tick && at_max) begin
          state_d = S_FULL;
        end else begin
          if (tick) time_d = bcd_inc(time_q);
          if (sw.start_stop) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (sw.clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          lap_d   = 1'b0;
        end else if (sw.start_stop) begin
          state_d = S_RUN;
        end
      end
      S_FULL: begin
        if (sw.clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          lap_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        time_d  = '0;
        lap_d   = 1'b0;
      end
    endcase
  end

  // The prescaler restarts a full period on every entry into RUN.
  // Any partial period is lost on pause.
  always_comb begin
    presc_d = PRESC_LOAD;
    if ((state_q == S_RUN) && (state_d == S_RUN) && (presc_q != '0)) begin
      presc_d = presc_q - 1'b1;
    end
  end

  // A freeze keeps the value already shown, which equals the live time on entry.
  assign display_d = lap_d ? display_q : time_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      presc_q   <= PRESC_LOAD;
      time_q    <= '0;
      display_q <= '0;
      lap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      display_q <= display_d;
      lap_q     <= lap_d;
    end
  end

  // Leading-zero blanking: digit n is lit if it or any higher digit is nonzero.
  always_comb begin
    logic any_nz;
    any_nz   = 1'b0;
    digit_en = 8'b0000_0111;
    for (int n = 7; n >= 3; n--) begin
      any_nz      = any_nz | (display_q[4*n +: 4] != 4'd0);
      digit_en[n] = any_nz;
    end
  end

  assign sw.display      = display_q;
  assign sw.digit_enable = digit_en;
  assign sw.dp_enable    = 8'b0101_0100 & digit_en;
  assign sw.running      = (state_q == S_RUN);
  assign sw.overflow     = (state_q == S_FULL);
  assign sw.lap_active   = lap_q;
  assign sw.dbg_state    = state_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at DIV=10. The reference keeps time as a count of
// hundredths and turns it into HH:MM:SS.hh with ordinary arithmetic.
module tb_stopwatch_core;
  localparam int CLOCK_FREQ = 1000;
  localparam int TICK_HZ    = 100;
  localparam int DIV        = CLOCK_FREQ / TICK_HZ;
  localparam int MAX_H      = 99*360000 + 59*6000 + 59*100 + 99;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int M_IDLE  = 10;
  localparam int M_RUN   = 11;
  localparam int M_PAUSE = 12;
  localparam int M_FULL  = 13;

  logic clk;
  logic resetn;
  stopwatch_core_if sw_if ();

  stopwatch_core #(.CLOCK_FREQ(CLOCK_FREQ), .TICK_HZ(TICK_HZ)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sw     (sw_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] preload_word;

  int m_state, m_h, m_phase, m_snap;
  bit m_lap;

  function automatic logic [31:0] to_bcd(input int h);
    int hu, s, m, hr;
    hu = h % 100;
    s  = (h / 100) % 60;
    m  = (h / 6000) % 60;
    hr = h / 360000;
    return {4'(hr / 10), 4'(hr % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(hu / 10), 4'(hu % 10)};
  endfunction

  // Magnitude thresholds: 10 s, 1 min, 10 min, 1 h and 10 h, in hundredths.
  function automatic logic [7:0] exp_de(input int h);
    logic [7:0] d;
    d = 8'h07;
    if (h >= 1000)    d[3] = 1'b1;
    if (h >= 6000)    d[4] = 1'b1;
    if (h >= 60000)   d[5] = 1'b1;
    if (h >= 360000)  d[6] = 1'b1;
    if (h >= 3600000) d[7] = 1'b1;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_h     = 0;
    m_phase = 0;
    m_lap   = 1'b0;
    m_snap  = 0;
  endtask

  // Reference behaviour for one clock edge, given the inputs applied in that cycle.
  task automatic model_step(input bit ss, input bit cl, input bit lp, input bit rn);
    int  nstate, nh;
    bit  tick, nlap;
    if (!rn) begin
      model_reset();
    end else begin
      tick   = (m_state == M_RUN) && (m_phase == DIV - 1);
      nstate = m_state;
      nh     = m_h;
      nlap   = m_lap;
      if (LAP_EN && lp) begin
        if (m_lap) nlap = 1'b0;
        else if (m_state == M_RUN) begin
          nlap   = 1'b1;
          m_snap = m_h;
        end
      end
      case (m_state)
        M_IDLE: if (ss) nstate = M_RUN;
        M_RUN: begin
          if (tick && m_h == MAX_H) nstate = M_FULL;
          else begin
            if (tick) nh = m_h + 1;
            if (ss) nstate = M_PAUSE;
          end
        end
        M_PAUSE: begin
          if (cl) begin nstate = M_IDLE; nh = 0; nlap = 1'b0; end
          else if (ss) nstate = M_RUN;
        end
        default: if (cl) begin nstate = M_IDLE; nh = 0; nlap = 1'b0; end
      endcase
      m_phase = (m_state == M_RUN && nstate == M_RUN && !tick) ? m_phase + 1 : 0;
      m_state = nstate;
      m_h     = nh;
      m_lap   = nlap;
    end
    exp_q.push_back(to_bcd(m_lap ? m_snap : m_h));
  endtask

  task automatic check_all();
    logic [31:0] exp_disp;
    int          dh;
    dh       = m_lap ? m_snap : m_h;
    exp_disp = exp_q.pop_front();
    chk("display", sw_if.display, exp_disp);
    chk("digit_enable", {24'd0, sw_if.digit_enable}, {24'd0, exp_de(dh)});
    chk("dp_enable", {24'd0, sw_if.dp_enable}, {24'd0, exp_de(dh) & 8'h54});
    chk("running", {31'd0, sw_if.running}, {31'd0, m_state == M_RUN});
    chk("overflow", {31'd0, sw_if.overflow}, {31'd0, m_state == M_FULL});
    chk("lap_active", {31'd0, sw_if.lap_active}, {31'd0, m_lap});
  endtask

  // driver: one clock cycle with the given pulses, then check after the edge
  task automatic step(input bit ss = 0, input bit cl = 0, input bit lp = 0, input bit rn = 1);
    sw_if.start_stop = ss;
    sw_if.clear      = cl;
    sw_if.lap        = lp;
    resetn           = rn;
    model_step(ss, cl, lp, rn);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Deposits a time value while the count is not advancing (IDLE or PAUSE).
  task automatic preload(input int h);
    preload_word = to_bcd(h);
    m_h          = h;
    force dut.time_q = preload_word;
    step();
    release dut.time_q;
  endtask

  initial begin
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    resetn           = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // reset values
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_display", sw_if.display, 32'h0);
    chk("reset_de", {24'd0, sw_if.digit_enable}, 32'h07);
    chk("reset_dp", {24'd0, sw_if.dp_enable}, 32'h04);

    // first tick DIV cycles after start
    step(1);
    repeat (9) step();
    chk("pre_first_tick", sw_if.display, 32'h0);
    step();
    chk("first_tick", sw_if.display, 32'h0000_0001);
    chk("first_tick_running", {31'd0, sw_if.running}, 32'd1);

    // clear ignored while running
    step(0, 1, 0);
    repeat (25) step();

    // pause, preload 00:00:59.98, resume through the minute carry
    step(1);
    repeat (15) step();
    preload(5998);
    step(1);
    repeat (20) step();
    chk("minute_carry", sw_if.display, 32'h0001_0000);
    chk("minute_carry_de", {24'd0, sw_if.digit_enable}, 32'h1F);
    chk("minute_carry_dp", {24'd0, sw_if.dp_enable}, 32'h14);

    // pausing mid-period discards it; the resume waits a full period
    repeat (4) step();
    step(1);
    repeat (7) step();
    step(1);
    repeat (9) step();
    chk("resume_no_early_tick", sw_if.display, 32'h0001_0000);
    step();
    chk("resume_tick", sw_if.display, 32'h0001_0001);

    // start_stop with clear in PAUSE: clear wins
    step(1);
    step(1, 1, 0);
    chk("pause_clear_display", sw_if.display, 32'h0);

    // saturate at 99:59:59.99
    preload(MAX_H - 1);
    step(1);
    repeat (20) step();
    chk("full_display", sw_if.display, 32'h9959_5999);
    chk("full_overflow", {31'd0, sw_if.overflow}, 32'd1);
    step(1);
    repeat (12) step();
    chk("full_ignores_start", {31'd0, sw_if.overflow}, 32'd1);
    step(0, 1, 0);
    chk("full_clear", sw_if.display, 32'h0);

    // tick and start_stop in the same cycle: increment, then pause
    step(1);
    repeat (9) step();
    step(1);
    chk("tick_with_pause", sw_if.display, 32'h0000_0001);
    chk("tick_with_pause_run", {31'd0, sw_if.running}, 32'd0);

    // reset mid-run
    step(1);
    repeat (13) step();
    step(0, 0, 0, 0);
    chk("midrun_reset", sw_if.display, 32'h0);
    chk("midrun_reset_de", {24'd0, sw_if.digit_enable}, 32'h07);

    // lap freeze at 00:00:01.23
    preload(123);
    step(1);
    repeat (5) step();
    step(0, 0, 1);
    chk("lap_snapshot", sw_if.display, 32'h0000_0123);
    repeat (30) step();
`ifdef STOPWATCH_LAP_EN
    chk("lap_frozen", sw_if.display, 32'h0000_0123);
`else
    chk("lap_ignored", sw_if.display, 32'h0000_0126);
`endif
    step(0, 0, 1);
    chk("lap_release", sw_if.display, 32'h0000_0126);

    // randomized pulses
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 499) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
